ham_7_4_dec_pipe: RTL and testbench

Streaming Hamming(7,4) single-error-correcting decoder, the receive-side counterpart of hamming_code_encoder.
- Accepts one 7-bit codeword per handshake, computes the 3-bit syndrome, flips the indicated bit and returns the 4-bit data word with error status.
- Two-stage registered pipeline with valid/ready flow control on both sides; sits between the storage/link read path and the consumer.

---
 rtl/ham_7_4_dec_pipe.sv | 151 +++++++++++++++
 tb/tb_ham_7_4_dec_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ham_7_4_dec_pipe.sv
// ham_7_4_dec_pipe
// Streaming Hamming(7,4) single-error-correcting decoder with a two-stage
// registered pipeline and valid/ready flow control on both sides.
// Codeword layout code_in[6:0] = positions 7..1 = {d4,d3,d2,p3,d1,p2,p1}.
// Optional feature: define HAM_DEC_ERR_CNT_EN to add the saturating
// corrected-error counter (err_cnt, cnt_clr) and its CNT_W parameter.
// Double-bit errors are not detected; the decoder flips whichever bit the
// syndrome points at, so such words come out miscorrected with err_corrected=1.

module ham_7_4_dec_pipe
`ifdef HAM_DEC_ERR_CNT_EN
  #(
    parameter int CNT_W = 16
  )
`endif
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       data_out,
    output logic             err_corrected,
    output logic [2:0]       syndrome
`ifdef HAM_DEC_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             cnt_clr
`endif
  );

  // Syndrome bits, each the parity over the positions whose index has that bit set.
  // The result equals the position of a single flipped bit, or 0 for a clean word.
  function automatic logic [2:0] calc_syndrome(input logic [6:0] c);
    logic s1;
    logic s2;
    logic s3;
    s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
    s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
    s3 = c[3] ^ c[4] ^ c[5] ^ c[6];
    return {s3, s2, s1};
  endfunction

  // One-hot flip mask for the position named by the syndrome; zero means no flip.
  function automatic logic [6:0] flip_mask(input logic [2:0] s);
    logic [6:0] m;
    case (s)
      3'd1:    m = 7'b000_0001;
      3'd2:    m = 7'b000_0010;
      3'd3:    m = 7'b000_0100;
      3'd4:    m = 7'b000_1000;
      3'd5:    m = 7'b001_0000;
      3'd6:    m = 7'b010_0000;
      3'd7:    m = 7'b100_0000;
      default: m = 7'b000_0000;
    endcase
    return m;
  endfunction

  // Data bits live at positions 7,6,5,3 of the codeword.
  function automatic logic [3:0] extract_data(input logic [6:0] c);
    return {c[6], c[5], c[4], c[2]};
  endfunction

  // Stage 1 holds the raw codeword and its syndrome.
  logic       s1_valid;
  logic [6:0] s1_code;
  logic [2:0] s1_syn;

  // Stage 2 holds the corrected data and status presented to the consumer.
  logic       s2_valid;
  logic [3:0] s2_data;
  logic [2:0] s2_syn;
  logic       s2_err;

  // Handshake and pipeline advance terms.
  logic       s2_adv;
  logic       s1_adv;
  logic [6:0] s1_fixed;

  // S2 may load whenever it is empty or its word is being taken this cycle.
  assign s2_adv   = !s2_valid || out_ready;

  // S1 moves forward only when it holds a word and S2 can take it.
  assign s1_adv   = s1_valid && s2_adv;

  // S1 accepts when it is empty or emptying; deliberately independent of in_valid.
  assign in_ready = !s1_valid || s2_adv;

  // Corrected codeword derived from the S1 contents, registered into S2.
  assign s1_fixed = s1_code ^ flip_mask(s1_syn);

  // Stage 1 register: capture the codeword and its syndrome on an input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= 7'd0;
      s1_syn   <= 3'd0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= code_in;
        s1_syn  <= calc_syndrome(code_in);
      end
    end
  end

  // Stage 2 register: load the corrected word, or a bubble when S1 is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= 4'd0;
      s2_syn   <= 3'd0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_adv) begin
        s2_data <= extract_data(s1_fixed);
        s2_syn  <= s1_syn;
        s2_err  <= (s1_syn != 3'd0);
      end
    end
  end

  // Outputs come straight from the S2 registers, so they stay put under backpressure.
  assign out_valid     = s2_valid;
  assign data_out      = s2_data;
  assign syndrome      = s2_syn;
  assign err_corrected = s2_err;

`ifdef HAM_DEC_ERR_CNT_EN
  logic out_fire;

  // A word leaves the decoder when the consumer takes a valid output.
  assign out_fire = out_valid && out_ready;

  // Saturating count of delivered words that needed a correction; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (out_fire && err_corrected && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ham_7_4_dec_pipe.sv
// tb_ham_7_4_dec_pipe
// Self-checking bench for ham_7_4_dec_pipe. A position-XOR model of the
// Hamming code predicts every delivered word; directed cases pin the model
// with hand-computed values. Counter checks exist when HAM_DEC_ERR_CNT_EN
// is defined (counter width 2 in that build).
`timescale 1ns/1ps

module tb_ham_7_4_dec_pipe;

  localparam int CNT_W = 2;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic [6:0] code_in   = 7'd0;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] data_out;
  logic       err_corrected;
  logic [2:0] syndrome;
`ifdef HAM_DEC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
  logic             cnt_clr = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] data;
    logic [2:0] syn;
    logic       err;
  } exp_t;

  exp_t expq[$];

  always #5 clk = ~clk;

`ifdef HAM_DEC_ERR_CNT_EN
  ham_7_4_dec_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .code_in(code_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .err_corrected(err_corrected), .syndrome(syndrome),
    .err_cnt(err_cnt), .cnt_clr(cnt_clr)
  );
`else
  ham_7_4_dec_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .code_in(code_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .err_corrected(err_corrected), .syndrome(syndrome)
  );
`endif

  // One comparison: count it and report any difference.
  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Syndrome = XOR of the indices of all set positions.
  function automatic logic [2:0] model_syndrome(input logic [6:0] c);
    int x = 0;
    for (int k = 1; k <= 7; k++)
      if (c[k-1]) x = x ^ k;
    return 3'(x);
  endfunction

  // Decode: flip the named position, read data from positions 7,6,5,3.
  function automatic exp_t model_decode(input logic [6:0] c);
    exp_t e;
    logic [6:0] f;
    logic [2:0] s;
    s = model_syndrome(c);
    f = c;
    if (s != 3'd0) f[int'(s) - 1] = ~f[int'(s) - 1];
    e.data = {f[6], f[5], f[4], f[2]};
    e.syn  = s;
    e.err  = (s != 3'd0);
    return e;
  endfunction

  // Encode: place data, then set parity positions 1,2,4 so the index XOR is zero.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    logic [2:0] x;
    c = 7'd0;
    c[6] = d[3];
    c[5] = d[2];
    c[4] = d[1];
    c[2] = d[0];
    x = model_syndrome(c);
    c[0] = x[0];
    c[1] = x[1];
    c[3] = x[2];
    return c;
  endfunction

  // Scoreboard: every cycle check flow control, hold stability, counter and outputs.
  bit         prevStall = 1'b0;
  logic [3:0] prevData;
  logic [2:0] prevSyn;
  logic       prevErr;
  int         modelCnt = 0;

  always @(negedge clk) begin
    exp_t e;
    bit   fire;
    bit   expErr;
    if (!rst_n) begin
      expq.delete();
      prevStall = 1'b0;
      modelCnt  = 0;
    end else begin
      checkOutput("in_ready", int'(in_ready),
                  int'(!(out_valid && !out_ready && expq.size() >= 2)));
      if (expq.size() == 0) checkOutput("idle_out_valid", int'(out_valid), 0);
      if (expq.size() >= 2) checkOutput("full_out_valid", int'(out_valid), 1);
      if (prevStall) begin
        checkOutput("hold_valid", int'(out_valid), 1);
        checkOutput("hold_data", int'(data_out), int'(prevData));
        checkOutput("hold_syndrome", int'(syndrome), int'(prevSyn));
        checkOutput("hold_err", int'(err_corrected), int'(prevErr));
      end
`ifdef HAM_DEC_ERR_CNT_EN
      checkOutput("err_cnt", int'(err_cnt), modelCnt);
`endif
      fire   = out_valid && out_ready;
      expErr = 1'b0;
      if (fire && expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("data_out", int'(data_out), int'(e.data));
        checkOutput("syndrome", int'(syndrome), int'(e.syn));
        checkOutput("err_corrected", int'(err_corrected), int'(e.err));
        expErr = e.err;
      end
`ifdef HAM_DEC_ERR_CNT_EN
      if (cnt_clr) modelCnt = 0;
      else if (fire && expErr && modelCnt < (2 ** CNT_W) - 1) modelCnt++;
`endif
      if (in_valid && in_ready) expq.push_back(model_decode(code_in));
      prevStall = out_valid && !out_ready;
      prevData  = data_out;
      prevSyn   = syndrome;
      prevErr   = err_corrected;
    end
  end

  // Drive one codeword until accepted (bounded), then drop in_valid.
  task automatic applyStimulus(input logic [6:0] code);
    bit acc = 1'b0;
    int n   = 0;
    in_valid = 1'b1;
    code_in  = code;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) checkOutput("accept_timeout", int'(acc), 1);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for the pipeline to empty.
  task automatic waitDrain();
    int n = 0;
    while ((expq.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_pending", expq.size(), 0);
  endtask

  // Single word with hand-computed results and exact two-cycle latency.
  task automatic runDirected(input string name, input logic [6:0] code,
                             input logic [3:0] expData, input logic [2:0] expSyn,
                             input logic expErr);
    out_ready = 1'b1;
    applyStimulus(code);
    checkOutput({name, "_early_valid"}, int'(out_valid), 0);
    @(posedge clk);
    #1;
    checkOutput({name, "_valid"}, int'(out_valid), 1);
    checkOutput({name, "_data"}, int'(data_out), int'(expData));
    checkOutput({name, "_syndrome"}, int'(syndrome), int'(expSyn));
    checkOutput({name, "_err"}, int'(err_corrected), int'(expErr));
    waitDrain();
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [6:0] c;
    logic [3:0] d;
    int         nf;

    // Reset state
    rst_n     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_data_out", int'(data_out), 0);
    checkOutput("rst_syndrome", int'(syndrome), 0);
    checkOutput("rst_err", int'(err_corrected), 0);
`ifdef HAM_DEC_ERR_CNT_EN
    checkOutput("rst_err_cnt", int'(err_cnt), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Hand-computed cases
    runDirected("clean",  7'b1100001, 4'b1100, 3'd0, 1'b0);
    runDirected("data5",  7'b1110001, 4'b1100, 3'd5, 1'b1);
    runDirected("par1",   7'b1010011, 4'b1010, 3'd1, 1'b1);
    runDirected("double", 7'b1010001, 4'b1011, 3'd3, 1'b1);

    // Backpressure: four words back-to-back with five stalled cycles
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(7'b1100001);
        applyStimulus(7'b1110001);
        applyStimulus(7'b1010011);
        applyStimulus(7'b1010001);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        checkOutput("bp_in_ready", int'(in_ready), 0);
        checkOutput("bp_out_valid", int'(out_valid), 1);
        checkOutput("bp_first_data", int'(data_out), 4'b1100);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();

    // Randomized traffic with 0, 1 or 2 bit errors and random backpressure
    for (int i = 0; i < 800; i++) begin
      d  = 4'($urandom);
      c  = encode(d);
      nf = $urandom_range(0, 2);
      for (int j = 0; j < nf; j++) c[$urandom_range(0, 6)] ^= 1'b1;
      in_valid  = ($urandom_range(0, 3) != 0);
      code_in   = c;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef HAM_DEC_ERR_CNT_EN
      cnt_clr   = ($urandom_range(0, 40) == 0);
`endif
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef HAM_DEC_ERR_CNT_EN
    cnt_clr   = 1'b0;
`endif
    waitDrain();

`ifdef HAM_DEC_ERR_CNT_EN
    // Counter saturation and clear priority
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    checkOutput("cnt_cleared", int'(err_cnt), 0);
    for (int i = 0; i < 5; i++) applyStimulus(7'b1110001);
    waitDrain();
    checkOutput("cnt_saturated", int'(err_cnt), 3);
    applyStimulus(7'b1110001);
    @(posedge clk);
    #1;
    checkOutput("clr_word_valid", int'(out_valid), 1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    checkOutput("cnt_clr_priority", int'(err_cnt), 0);
    waitDrain();
`endif

    // Reset in the middle of a stream
    out_ready = 1'b1;
    in_valid  = 1'b1;
    code_in   = 7'b1110001;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("mid_valid_before", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", int'(out_valid), 0);
    checkOutput("mid_rst_in_ready", int'(in_ready), 1);
    checkOutput("mid_rst_syndrome", int'(syndrome), 0);
`ifdef HAM_DEC_ERR_CNT_EN
    checkOutput("mid_rst_err_cnt", int'(err_cnt), 0);
`endif
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runDirected("after_rst", 7'b1100001, 4'b1100, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
